rx_medida_serial_7o1: RTL

Serial receiver and frame decoder for the distance message that the project datapath transmits over its 7O1 serial link. The message is three ASCII "digits" (nibble + 0x30) followed by '#' (0x23). The block deserialises 7O1 characters from RX and checks parity and stop bit. It reassembles the three nibbles into a 12-bit measurement and raises a one-cycle valid pulse. It sits on the monitoring side of the link, for example in a second board or a loopback test harness.

---
 rtl/rx_medida_serial_7o1.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/rx_medida_serial_7o1.sv
// rx_medida_serial_7o1: 7O1 serial receiver and decoder for the
// "ddd#" distance message (three ASCII digits, nibble + 0x30, then '#').
// Latency: outputs register one cycle after the stop-bit sample;
// RX itself is delayed 2 cycles by the input synchronizer.
// Backpressure: none, because the serial line cannot be stalled.
// Ports:
//   clock, reset    system clock, asynchronous active-high reset
//   RX              serial input, idle high
//   medida          last valid 12-bit measurement {d0,d1,d2}
//   medida_valida   1-cycle pulse when medida updates
//   erro_paridade   1-cycle pulse on odd-parity failure
//   erro_formato    1-cycle pulse on bad stop bit, illegal char or sequence
//   db_caractere    last 7-bit character received
//   db_estado       receive FSM state code
module rx_medida_serial_7o1 #(
  parameter int CLKS_POR_BIT = 434,
  parameter int N_CONT       = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        RX,
  output logic [11:0] medida,
  output logic        medida_valida,
  output logic        erro_paridade,
  output logic        erro_formato,
  output logic [6:0]  db_caractere,
  output logic [3:0]  db_estado
);

  typedef enum logic [2:0] {
    INICIAL      = 3'd0,
    ESPERA_START = 3'd1,
    DADOS        = 3'd2,
    PARIDADE     = 3'd3,
    STOP         = 3'd4,
    DECODIFICA   = 3'd5,
    ESPERA_LINHA = 3'd6
  } estado_t;

  localparam logic [N_CONT-1:0] FIM_BIT  = N_CONT'(CLKS_POR_BIT - 1);
  localparam logic [N_CONT-1:0] MEIO_BIT = N_CONT'(CLKS_POR_BIT / 2 - 1);

  estado_t           estado, prox_estado;
  logic              rx_meta, rx_sinc;
  logic [N_CONT-1:0] timer;
  logic [2:0]        cont_bits;
  logic [6:0]        dado;
  logic              bit_paridade;
  logic              bit_stop;
  logic [11:0]       acumulador;
  logic [1:0]        cont_dig;

  logic zera_timer;
  logic amostra;
  logic fim_meio, fim_bit;
  logic paridade_ok, eh_digito, eh_hash;

  // Both synchronizer stages reset to the idle level, so leaving reset never
  // looks like a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sinc <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sinc <= rx_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox_estado;
  end

  assign fim_meio = (timer == MEIO_BIT);
  assign fim_bit  = (timer == FIM_BIT);

  always_comb begin
    prox_estado = estado;
    zera_timer  = 1'b0;
    amostra     = 1'b0;
    case (estado)
      INICIAL: begin
        if (!rx_sinc) begin
          zera_timer  = 1'b1;
          prox_estado = ESPERA_START;
        end
      end
      ESPERA_START: begin
        // A start bit that is high again by mid-bit is a line glitch.
        if (fim_meio) begin
          zera_timer  = 1'b1;
          prox_estado = rx_sinc ? INICIAL : DADOS;
        end
      end
      DADOS: begin
        if (fim_bit) begin
          zera_timer = 1'b1;
          amostra    = 1'b1;
          if (cont_bits == 3'd6) prox_estado = PARIDADE;
        end
      end
      PARIDADE: begin
        if (fim_bit) begin
          zera_timer  = 1'b1;
          amostra     = 1'b1;
          prox_estado = STOP;
        end
      end
      STOP: begin
        if (fim_bit) begin
          zera_timer  = 1'b1;
          amostra     = 1'b1;
          prox_estado = DECODIFICA;
        end
      end
      DECODIFICA: begin
        // A missing stop bit means the line may still be low (break or
        // framing slip): wait for idle before hunting for a new start edge.
        prox_estado = bit_stop ? INICIAL : ESPERA_LINHA;
      end
      ESPERA_LINHA: begin
        if (rx_sinc) prox_estado = INICIAL;
      end
      default: prox_estado = INICIAL;
    endcase
  end

  // Odd parity: data plus parity bit must hold an odd number of ones.
  assign paridade_ok = ^{dado, bit_paridade};
  assign eh_digito   = (dado[6:4] == 3'b011);
  assign eh_hash     = (dado == 7'h23);

  // Bit timing and character assembly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer        <= '0;
      cont_bits    <= 3'd0;
      dado         <= 7'd0;
      bit_paridade <= 1'b0;
      bit_stop     <= 1'b1;
    end else begin
      if (zera_timer) timer <= '0;
      else            timer <= timer + 1'b1;

      if (estado == INICIAL) cont_bits <= 3'd0;

      if (amostra) begin
        case (estado)
          DADOS: begin
            dado      <= {rx_sinc, dado[6:1]};
            cont_bits <= cont_bits + 3'd1;
          end
          PARIDADE: bit_paridade <= rx_sinc;
          STOP:     bit_stop     <= rx_sinc;
          default:  ;
        endcase
      end
    end
  end

  // Message decode. Each rule is mutually exclusive, so at most one pulse
  // is raised per character.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      medida        <= 12'd0;
      medida_valida <= 1'b0;
      erro_paridade <= 1'b0;
      erro_formato  <= 1'b0;
      db_caractere  <= 7'd0;
      acumulador    <= 12'd0;
      cont_dig      <= 2'd0;
    end else begin
      medida_valida <= 1'b0;
      erro_paridade <= 1'b0;
      erro_formato  <= 1'b0;
      if (estado == DECODIFICA) begin
        db_caractere <= dado;
        if (!bit_stop) begin
          erro_formato <= 1'b1;
          cont_dig     <= 2'd0;
        end else if (!paridade_ok) begin
          erro_paridade <= 1'b1;
          cont_dig      <= 2'd0;
        end else if (eh_digito && cont_dig != 2'd3) begin
          acumulador <= {acumulador[7:0], dado[3:0]};
          cont_dig   <= cont_dig + 2'd1;
        end else if (eh_hash && cont_dig == 2'd3) begin
          medida        <= acumulador;
          medida_valida <= 1'b1;
          cont_dig      <= 2'd0;
        end else begin
          erro_formato <= 1'b1;
          cont_dig     <= 2'd0;
        end
      end
    end
  end

  assign db_estado = {1'b0, estado};

endmodule
